dcache: RTL and testbench
=========================

DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter LINES, default 64, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter MEM_ADDR_W, default 64, byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port dcache_en  input  1  one-cycle request strobe from memory stage.
REQ-006 SHALL have port dcache_wren  input  1  request is a write when high with dcache_en.
REQ-007 SHALL have port dcache_addr  input  64  byte address, sampled with dcache_en.
REQ-008 SHALL have port dcache_wdata  input  64  store data, sampled with dcache_en.
REQ-009 SHALL have port dcache_rdata  output  64  load data, valid only while dcache_done high.
REQ-010 SHALL have port dcache_done  output  1  one-cycle completion pulse per accepted request.
REQ-011 SHALL have ports mem_req (output, 1), mem_wren (output, 1), mem_addr (output, 64), mem_wdata (output, 64): backing-memory request, held stable until mem_ack.
REQ-012 SHALL have ports mem_rdata (input, 64) and mem_ack (input, 1): one-cycle memory completion; mem_rdata valid with mem_ack.

Function
REQ-013 SHALL be direct-mapped, one 64-bit word per line: offset addr[2:0] ignored, index addr[3+log2(LINES)-1:3], tag = remaining upper bits.
REQ-014 SHALL be write-through, no-write-allocate; at most one request outstanding.
REQ-015 SHALL implement states IDLE, LOOKUP, FILL, WRITE, RESP.
REQ-016 IDLE: dcache_en high -> latch addr/wdata/wren, go LOOKUP; otherwise stay.
REQ-017 LOOKUP, read hit -> latch line data into dcache_rdata, go RESP (read-hit latency: done 2 cycles after en cycle).
REQ-018 LOOKUP, read miss -> go FILL with mem_req=1, mem_wren=0, mem_addr = latched addr with [2:0] cleared.
REQ-019 LOOKUP, write -> if hit, update line data with wdata in same transition; go WRITE with mem_req=1, mem_wren=1, mem_addr = latched addr, mem_wdata = latched wdata.
REQ-020 FILL: on mem_ack -> install tag/data, set valid, dcache_rdata = mem_rdata, drop mem_req, go RESP.
REQ-021 WRITE: on mem_ack -> drop mem_req, go RESP; dcache_rdata value unspecified.
REQ-022 RESP: dcache_done=1 for exactly one cycle, then IDLE.
REQ-023 dcache_en outside IDLE SHALL be ignored with no state or array change.
REQ-024 mem_ack outside FILL/WRITE SHALL be ignored.
REQ-025 mem_req, mem_addr, mem_wren, mem_wdata SHALL remain constant from assertion through the mem_ack cycle.
REQ-026 Write miss SHALL leave valid/tag/data arrays unchanged.
REQ-027 Fill to a valid line SHALL overwrite it (no writeback needed).

Reset
REQ-028 reset high SHALL immediately force state IDLE, all valid bits 0, dcache_done 0, mem_req 0, mem_wren 0, dcache_rdata 0, mem_addr 0, mem_wdata 0.
REQ-029 Reset mid-FILL/WRITE SHALL abandon the transaction; a later mem_ack SHALL be ignored; tag/data arrays need no reset.

Structure
REQ-030 Shared package SHALL hold the state enum, LINES default, and index/tag width constants.
REQ-031 Tag/valid/data storage SHALL be a sub-module dcache_array (one read port, one write port, async valid clear).

Verification
REQ-032 Read 0x1000 after reset -> mem_req with mem_addr 0x1000; ack with 0xDEADBEEF -> done next cycle, rdata 0xDEADBEEF.
REQ-033 Re-read 0x1000 -> no mem_req; done exactly 2 cycles after en, rdata 0xDEADBEEF.
REQ-034 Write 0x1234 to 0x1000 -> mem_req/mem_wren with wdata 0x1234; after ack, read 0x1000 hits with rdata 0x1234.
REQ-035 Write 0x55 to 0x2000 (miss), then read 0x2000 -> read misses (no allocate) and issues fill.
REQ-036 Read 0x1200 (same index as 0x1000 for LINES=64) evicts; read 0x1000 then misses.
REQ-037 Assert reset during FILL, then pulse mem_ack -> no done, mem_req 0, read 0x1000 misses.

Source files
------------

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared constants and FSM state encoding for the data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    // Default geometry: 64 direct-mapped lines of one 64-bit word each.
    localparam int LINES_DEFAULT  = 64;
    localparam int ADDR_W_DEFAULT = 64;
    localparam int DATA_W         = 64;
    localparam int OFFSET_W       = 3;
    localparam int IDX_W_DEFAULT  = $clog2(LINES_DEFAULT);
    localparam int TAG_W_DEFAULT  = ADDR_W_DEFAULT - OFFSET_W - IDX_W_DEFAULT;

    // Controller states, kept as plain sized constants.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LOOKUP = 3'd1;
    localparam state_t S_FILL   = 3'd2;
    localparam state_t S_WRITE  = 3'd3;
    localparam state_t S_RESP   = 3'd4;

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_array
// Description : Valid/tag/data storage for the direct-mapped cache. One
//               combinational read port, one write port. Only the valid bits
//               are reset (asynchronously); tag and data come up undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_array #(
    parameter int LINES  = 64,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 55,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    // Valid bits: cleared by reset, set by any write (fill or write hit).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data storage; no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule : dcache_array
`default_nettype wire

// File: rtl/dcache.sv
`default_nettype none
// ============================================================================
// Module      : dcache
// Description : Direct-mapped, write-through, no-write-allocate data cache
//               with one 64-bit word per line and a single outstanding
//               request. Misses and all stores go to backing memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache
    import dcache_pkg::*;
#(
    parameter int LINES      = LINES_DEFAULT,
    parameter int MEM_ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dcache_en,
    input  logic                  dcache_wren,
    input  logic [MEM_ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0]     dcache_wdata,
    output logic [DATA_W-1:0]     dcache_rdata,
    output logic                  dcache_done,
    output logic                  mem_req,
    output logic                  mem_wren,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = MEM_ADDR_W - OFFSET_W - IDX_W;

    state_t                state_q, state_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  wren_q, wren_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_wren_q, mem_wren_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;
    logic              hit;
    logic              arr_wr_en;
    logic [DATA_W-1:0] arr_wr_data;

    // Index and tag always come from the latched request address.
    assign idx = addr_q[OFFSET_W +: IDX_W];
    assign tag = addr_q[MEM_ADDR_W-1 -: TAG_W];
    assign hit = line_valid && (line_tag == tag);

    // Array writes: store hit in LOOKUP, or line install when a fill is acked.
    assign arr_wr_en   = ((state_q == S_LOOKUP) && wren_q && hit)
                       || ((state_q == S_FILL) && mem_ack);
    assign arr_wr_data = (state_q == S_FILL) ? mem_rdata : wdata_q;

    dcache_array #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .rd_idx_i   (idx),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .wr_en_i    (arr_wr_en),
        .wr_idx_i   (idx),
        .wr_tag_i   (tag),
        .wr_data_i  (arr_wr_data)
    );

    // Next-state logic for the request controller and memory interface.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wren_d      = wren_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        mem_req_d   = mem_req_q;
        mem_wren_d  = mem_wren_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (dcache_en) begin
                    addr_d  = dcache_addr;
                    wdata_d = dcache_wdata;
                    wren_d  = dcache_wren;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (wren_q) begin
                    // Write-through: every store goes to memory, hit or miss.
                    mem_req_d   = 1'b1;
                    mem_wren_d  = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    state_d     = S_WRITE;
                end else if (hit) begin
                    rdata_d = line_data;
                    done_d  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_wren_d = 1'b0;
                    mem_addr_d = {addr_q[MEM_ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    rdata_d   = mem_rdata;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    mem_wren_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wren_q      <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wren_q      <= wren_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            mem_wren_q  <= mem_wren_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign dcache_rdata = rdata_q;
    assign dcache_done  = done_q;
    assign mem_req      = mem_req_q;
    assign mem_wren     = mem_wren_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule : dcache
`default_nettype wire

// File: tb/tb_dcache.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache
// Description : Scoreboard bench for dcache: directed scenarios followed by
//               random loads/stores, checked against a line/tag/memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache;

    logic        clk = 1'b0;
    logic        reset;
    logic        dcache_en, dcache_wren;
    logic [63:0] dcache_addr, dcache_wdata, dcache_rdata;
    logic        dcache_done;
    logic        mem_req, mem_wren;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack, resp_ack, stim_ack;

    assign mem_ack = resp_ack | stim_ack;

    dcache #(.LINES(64), .MEM_ADDR_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .dcache_en    (dcache_en),
        .dcache_wren  (dcache_wren),
        .dcache_addr  (dcache_addr),
        .dcache_wdata (dcache_wdata),
        .dcache_rdata (dcache_rdata),
        .dcache_done  (dcache_done),
        .mem_req      (mem_req),
        .mem_wren     (mem_wren),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_wr; logic [63:0] rdata; int lat; int en_cyc; } resp_t;
    typedef struct { bit wr; logic [63:0] addr; logic [63:0] data; } mreq_t;

    resp_t sb_q[$];
    mreq_t mq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    bit auto_ack = 1'b1;

    // Reference model: which line holds which tag, plus word-granular memory.
    bit          mvalid [64];
    logic [54:0] mtag   [64];
    logic [63:0] memory [logic [63:0]];

    function automatic logic [63:0] mem_val(input logic [63:0] wa);
        if (memory.exists(wa)) return memory[wa];
        return wa ^ 64'hC0FF_EE00_5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic [63:0] a, input bit w, input logic [63:0] d);
        int          idx;
        logic [54:0] t;
        logic [63:0] wa;
        bit          hit;
        resp_t       r;
        mreq_t       m;
        int          start;
        idx = int'(a[8:3]);
        t   = a[63:9];
        wa  = {a[63:3], 3'b000};
        hit = mvalid[idx] && (mtag[idx] == t);
        r.is_wr = w;
        r.rdata = mem_val(wa);
        r.lat   = (!w && hit) ? 2 : 0;
        if (w) begin
            m.wr = 1'b1; m.addr = a; m.data = d;
            mq.push_back(m);
            memory[wa] = d;
        end else if (!hit) begin
            m.wr = 1'b0; m.addr = wa; m.data = '0;
            mq.push_back(m);
            mvalid[idx] = 1'b1;
            mtag[idx]   = t;
        end
        @(posedge clk); #1;
        r.en_cyc = cyc;
        sb_q.push_back(r);
        start        = n_done;
        dcache_en    = 1'b1;
        dcache_wren  = w;
        dcache_addr  = a;
        dcache_wdata = d;
        @(posedge clk); #1;
        dcache_en    = 1'b0;
        dcache_wren  = 1'b0;
        for (int i = 0; i < 100 && n_done == start; i++) @(negedge clk);
        if (n_done == start) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done for addr %h", a);
            sb_q.delete();
            mq.delete();
        end
    endtask

    // Done monitor: pops the scoreboard on every completion pulse.
    resp_t mr;
    always @(negedge clk) begin
        if (!reset && dcache_done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done expected none");
            end else begin
                mr = sb_q.pop_front();
                if (!mr.is_wr) check("rdata", dcache_rdata, mr.rdata);
                if (mr.lat != 0) check("hit_latency", 64'(cyc - mr.en_cyc), 64'(mr.lat));
                check("mem_pending", 64'(mq.size()), 64'd0);
                mq.delete();
            end
        end
    end

    // Memory responder: checks each request and its stability, then acks.
    logic [63:0] ca, cd;
    logic        cw;
    int          dly;
    mreq_t       rm;
    initial begin
        resp_ack  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (auto_ack && mem_req && !reset) begin
                ca = mem_addr;
                cw = mem_wren;
                cd = mem_wdata;
                if (mq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_mem_req: got addr %h expected no request", ca);
                end else begin
                    rm = mq.pop_front();
                    check("mem_wren", 64'(cw), 64'(rm.wr));
                    check("mem_addr", ca, rm.addr);
                    if (rm.wr) check("mem_wdata", cd, rm.data);
                end
                dly = $urandom_range(0, 3);
                repeat (dly) begin
                    @(negedge clk);
                    check("mem_hold", 64'(mem_req === 1'b1 && mem_addr === ca &&
                          mem_wren === cw && mem_wdata === cd), 64'd1);
                end
                resp_ack  = 1'b1;
                mem_rdata = cw ? {$urandom, $urandom} : mem_val(ca);
                @(negedge clk);
                resp_ack  = 1'b0;
            end
        end
    end

    // Main stimulus: reset, directed scenarios, then random traffic.
    initial begin
        logic [63:0] a;
        bit          found;
        reset        = 1'b1;
        stim_ack     = 1'b0;
        dcache_en    = 1'b0;
        dcache_wren  = 1'b0;
        dcache_addr  = '0;
        dcache_wdata = '0;
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_done",     64'(dcache_done), 64'd0);
        check("rst_mem_req",  64'(mem_req),     64'd0);
        check("rst_mem_wren", 64'(mem_wren),    64'd0);
        check("rst_rdata",    dcache_rdata,     64'd0);
        check("rst_mem_addr", mem_addr,         64'd0);
        check("rst_mem_wdata", mem_wdata,       64'd0);
        reset = 1'b0;

        memory[64'h1000] = 64'hDEADBEEF;
        issue(64'h1000, 1'b0, 64'd0);         // cold miss, fill DEADBEEF
        issue(64'h1000, 1'b0, 64'd0);         // hit, latency 2
        issue(64'h1000, 1'b1, 64'h1234);      // write hit, write-through
        issue(64'h1000, 1'b0, 64'd0);         // hit with updated data
        issue(64'h2000, 1'b1, 64'h55);        // write miss, no allocate
        issue(64'h2000, 1'b0, 64'd0);         // must miss and fill
        issue(64'h1000, 1'b0, 64'd0);         // miss again (index 0 had 0x2000)
        issue(64'h1004, 1'b0, 64'd0);         // offset ignored: hit
        issue(64'h1200, 1'b0, 64'd0);         // same index, evicts 0x1000
        issue(64'h1000, 1'b0, 64'd0);         // miss after eviction

        // Reset while a fill is outstanding; the late ack must be ignored.
        auto_ack = 1'b0;
        @(posedge clk); #1;
        dcache_en   = 1'b1;
        dcache_wren = 1'b0;
        dcache_addr = 64'h3000;
        @(posedge clk); #1;
        dcache_en   = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = mem_req;
        end
        check("fill_req_seen", 64'(found), 64'd1);
        check("fill_req_addr", mem_addr, 64'h3000);
        reset = 1'b1;
        #1;
        check("async_rst_mem_req", 64'(mem_req), 64'd0);
        check("async_rst_done",    64'(dcache_done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        @(negedge clk);
        stim_ack = 1'b1;
        @(negedge clk);
        stim_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("late_ack_done",    64'(dcache_done), 64'd0);
            check("late_ack_mem_req", 64'(mem_req),     64'd0);
        end
        auto_ack = 1'b1;
        issue(64'h1000, 1'b0, 64'd0);         // valid bits cleared: miss

        // Random loads/stores over a few tags and indices to mix hits/misses.
        repeat (150) begin
            a = (64'($urandom_range(0, 3)) << 9) | (64'($urandom_range(0, 7)) << 3)
              | 64'($urandom_range(0, 7));
            issue(a, ($urandom_range(0, 9) < 4), {$urandom, $urandom});
        end

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        check("mq_empty", 64'(mq.size()),   64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dcache
`default_nettype wire
